// File: rtl/jtframe_rom_nslot_pkg.sv
// jtframe_rom_nslot_pkg: shared types and helpers for the N-slot ROM arbiter
package jtframe_rom_nslot_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam int OW = 22;
    function automatic logic [15:0] word_sel(input logic [31:0] w, input logic dw16, input logic [1:0] a);
        logic [31:0] s;
        s = w >> (dw16 ? {a[0], 4'd0} : {a, 3'd0});
        return dw16 ? s[15:0] : {8'd0, s[7:0]};
    endfunction
endpackage

// File: rtl/jtframe_rom_nslot_arb.sv
// jtframe_rom_nslot_arb: picks one pending slot, fixed or round-robin priority
module jtframe_rom_nslot_arb #(
    parameter int SLOTS = 9,
    parameter bit RR = 1'b0,
    parameter int IW = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [SLOTS-1:0] pending,
    input  logic             launch,
    output logic [IW-1:0]    win,
    output logic             any
);
    logic [IW-1:0] ptr;
    int j;
    // round-robin search starts just after the last winner
    always_comb begin
        win = '0;
        any = 1'b0;
        j = 0;
        for (int k = 0; k < SLOTS; k++) begin
            j = RR ? (int'(ptr) + 1 + k) % SLOTS : k;
            if (!any && pending[j[IW-1:0]]) begin
                win = j[IW-1:0];
                any = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= IW'(SLOTS - 1);
        else if (launch) ptr <= win;
    end
endmodule

// File: rtl/jtframe_rom_nslot.sv
// jtframe_rom_nslot: N-slot SDRAM ROM arbiter with a one-word cache per slot
module jtframe_rom_nslot import jtframe_rom_nslot_pkg::*; #(
    parameter int SLOTS = 9,
    parameter int SLOT_AW = 18,
    parameter logic [SLOTS-1:0] DW16 = '0,
    parameter logic [SLOTS*OW-1:0] OFFSET = '0,
    parameter bit RR = 1'b0
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     downloading,
    input  logic [SLOTS-1:0]         slot_cs,
    input  logic [SLOTS*SLOT_AW-1:0] slot_addr,
    output logic [SLOTS-1:0]         slot_ok,
    output logic [SLOTS*16-1:0]      slot_dout,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    output logic [OW-1:0]            sdram_addr,
    input  logic                     data_rdy,
    input  logic [31:0]              data_read
);
    localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    logic [SLOTS-1:0] hit, pending;
    logic [OW-1:0] cand [SLOTS];
    logic [SLOT_AW-2:0] tag_now [SLOTS];
    logic [SLOT_AW-2:0] tag_q;
    logic [IW-1:0] win, win_q;
    logic any, launch, fill;
    state_t state, state_nx;
    assign launch = state == IDLE && any && !downloading;
    assign fill = state == WAIT && data_rdy && !downloading;
    assign sdram_req = state == REQ && !downloading;
    jtframe_rom_nslot_arb #(.SLOTS(SLOTS), .RR(RR), .IW(IW)) u_arb (
        .clk(clk), .rst(rst), .pending(pending), .launch(launch), .win(win), .any(any)
    );
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [SLOT_AW-1:0] addr;
        logic [SLOT_AW-2:0] tag;
        logic [31:0] word;
        logic valid;
        assign addr = slot_addr[i*SLOT_AW +: SLOT_AW];
        // 8-bit tags are one bit shorter; pad so all slots share one tag width
        assign tag_now[i] = DW16[i] ? addr[SLOT_AW-1:1] : {1'b0, addr[SLOT_AW-1:2]};
        assign cand[i] = (OFFSET[i*OW +: OW] + OW'(DW16[i] ? addr : addr >> 1)) & ~OW'(1);
        assign hit[i] = valid && tag == tag_now[i];
        assign pending[i] = slot_cs[i] && !hit[i];
        assign slot_ok[i] = slot_cs[i] && hit[i] && !downloading;
        assign slot_dout[i*16 +: 16] = word_sel(word, DW16[i], addr[1:0]);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid <= 1'b0;
                tag <= '0;
                word <= '0;
            end else if (downloading) begin
                valid <= 1'b0;
            end else if (fill && win_q == IW'(i)) begin
                valid <= 1'b1;
                tag <= tag_q;
                word <= data_read;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = any ? REQ : IDLE;
            REQ: state_nx = sdram_ack ? WAIT : REQ;
            default: state_nx = data_rdy ? IDLE : WAIT;
        endcase
        if (downloading) state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            win_q <= '0;
            tag_q <= '0;
            sdram_addr <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                win_q <= win;
                tag_q <= tag_now[win];
                sdram_addr <= cand[win];
            end
        end
    end
endmodule

// File: doc/jtframe_rom_nslot.md
# jtframe_rom_nslot

Parametrised N-slot SDRAM ROM arbiter: successor to the fixed nine-slot ROM interface used by the game top levels. Each slot gets a one-word (32-bit) cache with tag. Misses are arbitrated by fixed or round-robin priority into a single SDRAM read port. Per-slot offset and data width (8/16) are parameters, so a core instantiates one block instead of hand-wiring slot ports.

## Interface
- SLOTS, 9, number of client slots (1..16)
- SLOT_AW, 18, address width of every slot port (unused MSBs tied 0 by caller)
- DW16, 0, SLOTS-bit mask; bit i=1 → slot i is 16-bit, else 8-bit
- OFFSET, 0, packed SLOTS×22-bit SDRAM 16-bit-word offsets, slot i at [22i+21:22i]
- RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- downloading  in  1  ROM download in progress; blocks and flushes
- slot_cs  in  SLOTS  per-slot request
- slot_addr  in  SLOTS×SLOT_AW  packed slot addresses, in units of the slot's data width
- slot_ok  out  SLOTS  data valid for current slot_addr
- slot_dout  out  SLOTS×16  packed data; 8-bit slots use [7:0], [15:8]=0
- sdram_req  out  1  read request
- sdram_ack  in  1  controller accepted request
- sdram_addr  out  22  16-bit-word address, always even (32-bit aligned)
- data_rdy  in  1  data_read valid, one cycle
- data_read  in  32  read data, little-endian (byte 0 = [7:0])

## Operation
- Per slot: valid bit, tag, 32-bit cached word. Tag = addr[SLOT_AW-1:2] (8-bit) or addr[SLOT_AW-1:1] (16-bit).
- Hit = valid & tag match. slot_ok[i] = slot_cs[i] & hit & ~downloading, combinational from registers and inputs.
- slot_dout selects from the cached word: 8-bit by addr[1:0], 16-bit by addr[0]. Combinational.
- Miss = slot_cs & ~hit. Pending vector = miss of all slots.
- SDRAM address = OFFSET[i] + (addr>>1 for 8-bit | addr for 16-bit), bit 0 forced to 0. Sum is 22 bits; overflow wraps silently.
- FSM:
  - IDLE: if pending ≠ 0 and ~downloading, latch winner index, its tag and sdram_addr → REQ.
  - REQ: sdram_req=1; on sdram_ack → WAIT. data_rdy here is ignored.
  - WAIT: on data_rdy, write data_read into the winner's cache, set its tag and valid → IDLE.
- Fixed priority: lowest pending index wins.
- Round-robin: search starts at last winner+1, wrapping modulo SLOTS.
- Slot address or cs changing mid-flight: the fetch still completes and fills the latched tag. slot_ok reflects the new address against that tag.
- downloading=1: FSM forced to IDLE, sdram_req=0, all valid bits cleared every cycle. An in-flight fetch is abandoned; a late data_rdy is ignored.

## Timing
- Reset values:
  - FSM IDLE; sdram_req 0; sdram_addr 0.
  - All valid 0, all cache words 0.
  - slot_ok 0; slot_dout 0.
  - RR pointer at SLOTS-1, so slot 0 is searched first.
- Hit: slot_ok in the same cycle the address matches; 0 added latency.
- Miss seen in IDLE at cycle N: sdram_req=1 and sdram_addr stable from N+1 until the cycle after ack.
- sdram_ack at cycle M: sdram_req=0 at M+1.
- data_rdy at cycle K: cache and valid updated at K+1, so slot_ok=1 at K+1 for a matching address. FSM is in IDLE at K+1; next request starts at K+2.
- One outstanding request at most. sdram_addr holds its value between requests.

## Structure
- Package jtframe_rom_nslot_pkg: FSM state enum (IDLE/REQ/WAIT), offset-field width constant (22), byte/half select function.
- Sub-module jtframe_rom_nslot_arb: combinational pending→winner picker (fixed/RR) with registered RR pointer. Pointer updates only when IDLE launches a request.
- Per-slot cache logic as a generate loop in the top.

## Test plan
- Reset, SLOTS=3, slot0 8-bit OFFSET=0x28000, cs=1 addr=0x0005. Controller acks after 3 cycles, data_rdy with 0x44332211. Expected:
  - sdram_addr=0x28002.
  - slot_ok rises the cycle after data_rdy.
  - slot_dout=0x0022 (byte 1).
- Same slot then steps addr 0x0004→0x0006→0x0007: slot_ok stays 1 (hit, no new sdram_req), dout 0x11,0x33,0x44.
- Slots 0,1,2 all miss simultaneously:
  - RR=0: grant order 0,1,2.
  - RR=1 with last winner=1: grant order 2,0,1.
- 16-bit slot1 OFFSET=0x80000, addr=0x3 → sdram_addr=0x80002. data_read 0xBBBBAAAA → dout 0xBBBB.
- downloading asserted while in WAIT: sdram_req=0, all slot_ok=0. data_rdy during download does not set valid. After download ends, the same address re-requests.
- Async rst asserted mid-REQ: sdram_req drops without waiting for a clock edge; all valid bits clear.
